// File: rtl/sg_scheduler_if.sv
// Program-channel and tag-output handshake bundle for the spike generator scheduler.
// slave = scheduler side, master = config mapper / BD output side.
interface sg_scheduler_if #(
   parameter int N_SG_gens   = 8,
   parameter int N_SG_period = 16,
   parameter int N_SG_tag    = 11
) ();
   logic [N_SG_gens-1:0]   prog_gen_idx;
   logic [N_SG_period-1:0] prog_period;
   logic [N_SG_period-1:0] prog_ticks;
   logic [N_SG_tag-1:0]    prog_tag;
   logic                   prog_v;
   logic                   prog_a;
   logic [N_SG_tag-1:0]    out_tag;
   logic [N_SG_gens-1:0]   out_gen_idx;
   logic                   out_v;
   logic                   out_a;

   modport slave (
      input  prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_v,
      output prog_a,
      output out_tag, out_gen_idx, out_v,
      input  out_a
   );

   modport master (
      output prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_v,
      input  prog_a,
      input  out_tag, out_gen_idx, out_v,
      output out_a
   );
endinterface

// File: rtl/sg_scheduler.sv
// Time-driven spike generator scheduler: per-pulse sweep over a {period, ticks, tag} RAM.
// Optional SG_SCHEDULER_MISS_COUNT_EN enables the saturating lost-pulse counter.
module sg_scheduler #(
   parameter int N_SG_gens   = 8,
   parameter int N_SG_period = 16,
   parameter int N_SG_tag    = 11,
   parameter int N_MISS      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     time_unit_pulse,
   input  logic [N_SG_gens-1:0]     gens_used,
   input  logic [2**N_SG_gens-1:0]  gens_en,
   sg_scheduler_if.slave            sg,
   output logic                     busy,
   output logic                     overrun,
   input  logic                     overrun_clr,
   output logic [N_MISS-1:0]        miss_count
);
   localparam int DEPTH = 2**N_SG_gens;
   localparam int W     = 2*N_SG_period + N_SG_tag;

   typedef enum logic [1:0] {IDLE, READ, EVAL, EMIT} state_t;

   state_t                 state_reg, state_next;
   logic [N_SG_gens-1:0]   idx_reg, idx_next;
   logic                   pending_reg, pending_next;
   logic [N_SG_tag-1:0]    out_tag_reg;
   logic [N_SG_gens-1:0]   out_idx_reg;
   logic                   overrun_reg;
   logic                   fire, advance, lost, prog_ok;

   logic [W-1:0]           mem [DEPTH];
   logic [W-1:0]           rd_data;
   logic                   mem_we;
   logic [N_SG_gens-1:0]   mem_addr;
   logic [W-1:0]           mem_wdata;

   logic [N_SG_period-1:0] e_period, e_ticks;
   logic [N_SG_tag-1:0]    e_tag;

   assign e_period = rd_data[W-1 -: N_SG_period];
   assign e_ticks  = rd_data[N_SG_tag +: N_SG_period];
   assign e_tag    = rd_data[N_SG_tag-1:0];

   // Single-port RAM, registered read; contents deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_addr] <= mem_wdata;
      rd_data <= mem[mem_addr];
   end

   assign prog_ok = (state_reg == IDLE) & sg.prog_v & ~time_unit_pulse & ~pending_reg;

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      pending_next = pending_reg;
      mem_we       = 1'b0;
      mem_addr     = idx_reg;
      mem_wdata    = rd_data;
      fire         = 1'b0;
      advance      = 1'b0;
      lost         = 1'b0;
      case (state_reg)
         IDLE: begin
            mem_addr  = sg.prog_gen_idx;
            mem_wdata = {sg.prog_period, sg.prog_ticks, sg.prog_tag};
            mem_we    = prog_ok;
            if (time_unit_pulse | pending_reg) begin
               // A fresh pulse landing on the queued one stays queued.
               pending_next = pending_reg & time_unit_pulse;
               if (gens_used != '0) begin
                  state_next = READ;
                  idx_next   = '0;
               end
            end
         end
         READ: state_next = EVAL;
         EVAL: begin
            if (gens_en[idx_reg] && e_period != '0) begin
               mem_we = 1'b1;
               if (e_ticks != '0) begin
                  mem_wdata = {e_period, e_ticks - 1'b1, e_tag};
                  advance   = 1'b1;
               end else begin
                  mem_wdata  = {e_period, e_period - 1'b1, e_tag};
                  fire       = 1'b1;
                  state_next = EMIT;
               end
            end else begin
               advance = 1'b1;
            end
         end
         EMIT: advance = sg.out_a;
         default: state_next = IDLE;
      endcase
      if (advance) begin
         if (idx_reg == gens_used - 1'b1) begin
            state_next = IDLE;
         end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = READ;
         end
      end
      if (time_unit_pulse && state_reg != IDLE) begin
         if (!pending_reg)
            pending_next = 1'b1;
         else
            lost = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         pending_reg <= 1'b0;
         out_tag_reg <= '0;
         out_idx_reg <= '0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         pending_reg <= pending_next;
         if (fire) begin
            out_tag_reg <= e_tag;
            out_idx_reg <= idx_reg;
         end
         if (overrun_clr)
            overrun_reg <= 1'b0;
         else if (lost)
            overrun_reg <= 1'b1;
      end
   end

`ifdef SG_SCHEDULER_MISS_COUNT_EN
   logic [N_MISS-1:0] miss_reg;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         miss_reg <= '0;
      else if (overrun_clr)
         miss_reg <= '0;
      else if (lost && miss_reg != '1)
         miss_reg <= miss_reg + 1'b1;
   end
   assign miss_count = miss_reg;
`else
   assign miss_count = '0;
`endif

   assign sg.prog_a      = prog_ok;
   assign sg.out_v       = (state_reg == EMIT);
   assign sg.out_tag     = out_tag_reg;
   assign sg.out_gen_idx = out_idx_reg;
   assign busy           = (state_reg != IDLE);
   assign overrun        = overrun_reg;
endmodule

// File: tb/tb_sg_scheduler.sv
// Directed scoreboard bench for sg_scheduler: stimulus pushes expected tags, a negedge
// monitor pops and compares every accepted output.
`timescale 1ns/1ps
module tb_sg_scheduler;
   localparam int NG = 8;
   localparam int NP = 16;
   localparam int NT = 11;
   localparam int NM = 16;

   typedef struct packed {
      logic [NT-1:0] tag;
      logic [NG-1:0] idx;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            time_unit_pulse = 1'b0;
   logic            overrun_clr = 1'b0;
   logic [NG-1:0]   gens_used = '0;
   logic [2**NG-1:0] gens_en = '0;
   logic            busy, overrun;
   logic [NM-1:0]   miss_count;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   miss_exp;

   sg_scheduler_if #(.N_SG_gens(NG), .N_SG_period(NP), .N_SG_tag(NT)) bus ();

   sg_scheduler #(.N_SG_gens(NG), .N_SG_period(NP), .N_SG_tag(NT), .N_MISS(NM)) dut (
      .clk             (clk),
      .reset           (reset),
      .time_unit_pulse (time_unit_pulse),
      .gens_used       (gens_used),
      .gens_en         (gens_en),
      .sg              (bus),
      .busy            (busy),
      .overrun         (overrun),
      .overrun_clr     (overrun_clr),
      .miss_count      (miss_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [NT-1:0] tag, input logic [NG-1:0] idx);
      exp_t e;
      e.tag = tag;
      e.idx = idx;
      exp_q.push_back(e);
   endtask

   task automatic pulse();
      time_unit_pulse = 1'b1;
      tick();
      time_unit_pulse = 1'b0;
   endtask

   task automatic prog(input logic [NG-1:0] i, input logic [NP-1:0] p,
                       input logic [NP-1:0] t, input logic [NT-1:0] g);
      int n;
      bus.prog_gen_idx = i;
      bus.prog_period  = p;
      bus.prog_ticks   = t;
      bus.prog_tag     = g;
      bus.prog_v       = 1'b1;
      n = 0;
      while (!bus.prog_a && n < 200) begin
         tick();
         n++;
      end
      check("prog_ack", bus.prog_a, 1);
      tick();
      bus.prog_v = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 500) begin
         tick();
         n++;
      end
      check("sweep_end", busy, 0);
   endtask

   task automatic wait_outv();
      int n;
      n = 0;
      while (!bus.out_v && n < 50) begin
         tick();
         n++;
      end
      check("out_v_rise", bus.out_v, 1);
   endtask

   // Scoreboard monitor: a handshake completes on the posedge following this sample.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.out_v === 1'b1 && bus.out_a === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_tag: got tag 0x%0h gen %0d, expected none",
                        bus.out_tag, bus.out_gen_idx);
            end else begin
               e = exp_q.pop_front();
               if (bus.out_tag !== e.tag || bus.out_gen_idx !== e.idx) begin
                  errors++;
                  $display("FAIL tag_out: got tag 0x%0h gen %0d, expected tag 0x%0h gen %0d",
                           bus.out_tag, bus.out_gen_idx, e.tag, e.idx);
               end else begin
                  $display("tx tag=0x%0h gen=%0d", bus.out_tag, bus.out_gen_idx);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef SG_SCHEDULER_MISS_COUNT_EN
      miss_exp = 1;
`else
      miss_exp = 0;
`endif
      bus.prog_v = 1'b0;
      bus.prog_gen_idx = '0;
      bus.prog_period = '0;
      bus.prog_ticks = '0;
      bus.prog_tag = '0;
      bus.out_a = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_prog_a", bus.prog_a, 0);
      check("rst_out_v", bus.out_v, 0);
      check("rst_out_tag", bus.out_tag, 0);
      check("rst_out_idx", bus.out_gen_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_miss", miss_count, 0);
      reset = 1'b1;
      tick();

      // Single generator, period 3: fires on pulses 1, 4, 7 with 3-cycle latency
      prog(8'd0, 16'd3, 16'd0, 11'h155);
      gens_used = 8'd1;
      gens_en[0] = 1'b1;
      for (int p = 1; p <= 7; p++) begin
         bit fire;
         fire = (p == 1 || p == 4 || p == 7);
         if (fire) push(11'h155, 8'd0);
         pulse();
         check("lat1_out_v", bus.out_v, 0);
         tick();
         check("lat2_out_v", bus.out_v, 0);
         tick();
         check("lat3_out_v", bus.out_v, fire);
         wait_idle();
      end

      // Four generators, gens_en = 0101: each pulse emits gen 0 then gen 2
      for (int i = 0; i < 4; i++)
         prog(i[NG-1:0], 16'd1, 16'd0, 11'h10 + i[NT-1:0]);
      gens_en[3:0] = 4'b0101;
      gens_used = 8'd4;
      for (int p = 0; p < 2; p++) begin
         push(11'h10, 8'd0);
         push(11'h12, 8'd2);
         pulse();
         wait_idle();
      end

      // Backpressure: output held stable for 20 cycles
      bus.out_a = 1'b0;
      push(11'h10, 8'd0);
      push(11'h12, 8'd2);
      pulse();
      wait_outv();
      check("hold_tag0", bus.out_tag, 11'h10);
      check("hold_idx0", bus.out_gen_idx, 0);
      for (int c = 0; c < 20; c++) begin
         tick();
         check("hold_v", bus.out_v, 1);
         check("hold_tag", bus.out_tag, 11'h10);
      end
      bus.out_a = 1'b1;
      wait_idle();

      // Three pulses in one sweep: one queued, one lost
      bus.out_a = 1'b0;
      push(11'h10, 8'd0);
      push(11'h12, 8'd2);
      pulse();
      repeat (3) tick();
      pulse();
      check("pending_no_overrun", overrun, 0);
      tick();
      pulse();
      check("overrun_set", overrun, 1);
      check("miss_one", miss_count, miss_exp);
      push(11'h10, 8'd0);
      push(11'h12, 8'd2);
      bus.out_a = 1'b1;
      wait_idle();
      tick();
      check("b2b_one_idle", busy, 1);
      wait_idle();
      check("overrun_sticky", overrun, 1);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check("overrun_clr", overrun, 0);
      check("miss_clr", miss_count, 0);

      // Program and pulse in the same IDLE cycle: pulse wins, write lands afterwards
      gens_used = 8'd1;
      bus.prog_gen_idx = 8'd0;
      bus.prog_period = 16'd0;
      bus.prog_ticks = 16'd0;
      bus.prog_tag = 11'h077;
      bus.prog_v = 1'b1;
      time_unit_pulse = 1'b1;
      #1;
      check("prog_a_vs_pulse", bus.prog_a, 0);
      push(11'h10, 8'd0);
      tick();
      time_unit_pulse = 1'b0;
      begin
         int n;
         n = 0;
         while (busy && n < 100) begin
            check("prog_a_busy", bus.prog_a, 0);
            tick();
            n++;
         end
      end
      check("prog_a_idle", bus.prog_a, 1);
      tick();
      bus.prog_v = 1'b0;
      for (int p = 0; p < 2; p++) begin
         pulse();
         tick();
         tick();
         check("period0_nofire", bus.out_v, 0);
         wait_idle();
      end

      // Reset while in EMIT, then a clean sweep from gen 0
      gens_used = 8'd2;
      gens_en[3:0] = 4'b0011;
      prog(8'd0, 16'd2, 16'd0, 11'h2AA);
      prog(8'd1, 16'd1, 16'd0, 11'h0B1);
      bus.out_a = 1'b0;
      pulse();
      wait_outv();
      check("emit_tag_before_rst", bus.out_tag, 11'h2AA);
      reset = 1'b0;
      #1;
      check("rst_emit_out_v", bus.out_v, 0);
      check("rst_emit_busy", busy, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.out_a = 1'b1;
      tick();
      push(11'h0B1, 8'd1);
      pulse();
      wait_idle();
      push(11'h2AA, 8'd0);
      push(11'h0B1, 8'd1);
      pulse();
      wait_idle();

      // gens_used == 0: pulse consumed without a sweep
      gens_used = 8'd0;
      pulse();
      check("gens0_busy", busy, 0);
      tick();
      check("gens0_busy2", busy, 0);

      repeat (5) tick();
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sg_scheduler.md
# sg_scheduler

Time-driven scheduler for the spike generator array. Holds per-generator program state (period, ticks-remaining, tag) in a single-port memory loaded over the SpikeGenerator program channel. On every time-unit pulse from the time manager it sweeps generators `0..gens_used-1` and emits a tag for each enabled generator whose countdown expires. Sits between the PC config mapper and the tag output path toward BD.

## Interface
- `N_SG_gens`, default 8: generator index width; memory depth `2**N_SG_gens`.
- `N_SG_period`, default 16: period and ticks width.
- `N_SG_tag`, default 11: tag width.
- `N_MISS`, default 16: miss counter width.

- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `time_unit_pulse`  in  1  one-cycle strobe from the time manager.
- `gens_used`  in  N_SG_gens  number of generators swept; 0 means none.
- `gens_en`  in  2**N_SG_gens  per-generator enable.
- `prog_gen_idx`  in  N_SG_gens  program-channel target index.
- `prog_period`  in  N_SG_period  program-channel period.
- `prog_ticks`  in  N_SG_period  program-channel initial ticks.
- `prog_tag`  in  N_SG_tag  program-channel tag.
- `prog_v`  in  1  program-channel valid.
- `prog_a`  out  1  program-channel ack.
- `out_tag`  out  N_SG_tag  emitted tag.
- `out_gen_idx`  out  N_SG_gens  index of the generator that fired.
- `out_v`  out  1  output valid.
- `out_a`  in  1  output ack.
- `busy`  out  1  sweep in progress.
- `overrun`  out  1  sticky; set when a pulse is lost.
- `overrun_clr`  in  1  clears `overrun` and `miss_count`.
- `miss_count`  out  N_MISS  saturating count of lost pulses.

## Operation
- Memory entry: `{period, ticks, tag}`. Contents are not reset.
- States:
  - IDLE: default state.
  - READ: memory address = `idx`.
  - EVAL: read data valid.
  - EMIT: output held.
- IDLE:
  - `prog_a = prog_v & ~time_unit_pulse & ~pending` (combinational).
  - On `prog_v & prog_a`, write `mem[prog_gen_idx]` on that edge.
  - On `time_unit_pulse` (or `pending`) with `gens_used != 0`: go to READ with `idx=0` and clear `pending`.
  - If `gens_used == 0`, the pulse is consumed and the state stays IDLE.
- READ -> EVAL unconditionally.
- EVAL, for entry `e` and `en = gens_en[idx]`:
  - `en == 0` or `e.period == 0`: no write-back; advance.
  - `e.ticks != 0`: write `ticks-1`; advance.
  - `e.ticks == 0`: write `ticks = e.period - 1`; latch `out_tag = e.tag` and `out_gen_idx = idx`; go to EMIT.
- EMIT: `out_v = 1` until `out_a`. On the acknowledging edge drop `out_v` and advance.
- Advance: if `idx == gens_used-1`, go to IDLE; else `idx+1` and go to READ.
- Pulse while `busy`:
  - If `pending == 0`, set `pending`.
  - Otherwise set `overrun` and increment `miss_count`.
- `gens_used` and `gens_en` are sampled live each EVAL. Changing them mid-sweep takes effect at the next compare.
- `overrun_clr` has priority over a same-cycle increment.

## Timing
- Reset values: `prog_a=0`, `out_v=0`, `out_tag=0`, `out_gen_idx=0`, `busy=0`, `overrun=0`, `miss_count=0`.
- After reset: state IDLE, `pending=0`, `idx=0`.
- Reset asserted mid-sweep or mid-EMIT: `out_v` drops immediately (asynchronous). Partially swept state is kept as-is in memory.
- `busy=1` in READ, EVAL and EMIT.
- Sweep cost: 2 cycles per non-firing generator; 3 cycles plus `out_a` wait per firing generator.
- First `out_v` appears 3 cycles after the `time_unit_pulse` edge when generator 0 fires with `out_a` held high.
- `out_v` and its data are stable until acknowledged. There is no combinational path from `out_a` to `out_v`.
- Simultaneous pulse and `prog_v` in IDLE: the pulse wins and `prog_a=0`.
- Back-to-back sweep: when `pending` is set, IDLE lasts exactly 1 cycle.

## Configuration
- `SG_SCHEDULER_MISS_COUNT_EN` defined: `miss_count` is a saturating `N_MISS`-bit counter that holds at all-ones.
- Undefined: `miss_count` is tied to 0. The `overrun` flag is unaffected.

## Test plan
- Program generator 0 with `period=3`, `ticks=0`, `tag=0x155`; set `gens_used=1`, `gens_en[0]=1`, `out_a=1`; apply 7 pulses. Tags emitted on pulses 1, 4 and 7 only, each with `out_gen_idx=0` and arriving 3 cycles after the pulse.
- Program generators 0..3 with `period=1`, `ticks=0`; set `gens_en=4'b0101` and `gens_used=4`. Each pulse emits exactly gen 0 then gen 2, in that order.
- Hold `out_a=0` for 20 cycles during EMIT. `out_v` and `out_tag` stay stable, with no duplicate or lost tag after release.
- With `out_a=0`, apply 3 pulses during one sweep. Expect `pending` to start a back-to-back sweep, `overrun=1` and `miss_count=1`. `overrun_clr` returns both to 0; with the macro undefined, `miss_count` stays 0.
- Apply `prog_v` and a pulse in the same IDLE cycle. `prog_a=0` until the sweep ends, then the write lands and the next sweep uses the new value. `period=0` never fires.
- Assert `reset` low while in EMIT. `out_v=0` and `busy=0` immediately; the next pulse after release starts a clean sweep from `idx=0`.
